// File: rtl/regex_pc_dispatcher_if.sv
// Handshake bundle between the PC dispatcher and its surroundings: seed
// front-end, CPU output PC stream, CPU input PC port and status flags.
interface regex_pc_dispatcher_if #(
    parameter int PC_WIDTH        = 9,
    parameter int CC_ID_BITS      = 2,
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic                       seed_valid;
    logic [PC_WIDTH-1:0]        seed_pc;
    logic [CC_ID_BITS-1:0]      seed_cc_id;
    logic                       seed_ready;

    logic                       cpu_out_valid;
    logic [PC_WIDTH-1:0]        cpu_out_pc;
    logic [CC_ID_BITS-1:0]      cpu_out_cc_id;
    logic                       cpu_out_ready;

    logic                       cpu_in_valid;
    logic [PC_WIDTH-1:0]        cpu_in_pc;
    logic [CC_ID_BITS-1:0]      cpu_in_cc_id;
    logic                       cpu_in_ready;

    logic                       cpu_running;
    logic [FIFO_DEPTH_LOG2:0]   occupancy;
    logic [FIFO_DEPTH_LOG2:0]   max_occupancy;
    logic                       full;
    logic                       empty;
    logic                       idle;

    modport master (
        output seed_valid, seed_pc, seed_cc_id,
        input  seed_ready,
        output cpu_out_valid, cpu_out_pc, cpu_out_cc_id,
        input  cpu_out_ready,
        input  cpu_in_valid, cpu_in_pc, cpu_in_cc_id,
        output cpu_in_ready,
        output cpu_running,
        input  occupancy, max_occupancy, full, empty, idle
    );

    modport slave (
        input  seed_valid, seed_pc, seed_cc_id,
        output seed_ready,
        input  cpu_out_valid, cpu_out_pc, cpu_out_cc_id,
        output cpu_out_ready,
        output cpu_in_valid, cpu_in_pc, cpu_in_cc_id,
        input  cpu_in_ready,
        input  cpu_running,
        output occupancy, max_occupancy, full, empty, idle
    );
endinterface

// File: rtl/regex_pc_dispatcher.sv
// Circular (cc_id, pc) work queue feeding the regex CPU from its own output
// stream and from external seeds; reports occupancy, high-watermark and idle.
module regex_pc_dispatcher #(
    parameter int PC_WIDTH        = 9,
    parameter int CC_ID_BITS      = 2,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    regex_pc_dispatcher_if.slave bus
);
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int OCC_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int ENTRY_W = CC_ID_BITS + PC_WIDTH;

    localparam logic [OCC_W-1:0]           OCC_ZERO  = OCC_W'(0);
    localparam logic [OCC_W-1:0]           OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0]           OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO  = FIFO_DEPTH_LOG2'(0);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

    logic [ENTRY_W-1:0]         mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wp_r;
    logic [FIFO_DEPTH_LOG2-1:0] rp_r;
    logic [OCC_W-1:0]           occ_r;
    logic [OCC_W-1:0]           max_occ_r;

    logic                       full_s;
    logic                       empty_s;
    logic                       pop_fire_s;
    logic                       space_s;
    logic                       cpu_push_s;
    logic                       seed_push_s;
    logic                       push_s;
    logic [ENTRY_W-1:0]         push_data_s;
    logic [OCC_W-1:0]           occ_next_s;
    logic [OCC_W-1:0]           max_next_s;

    assign full_s      = (occ_r == OCC_FULL);
    assign empty_s     = (occ_r == OCC_ZERO);
    assign pop_fire_s  = !empty_s && bus.cpu_in_ready;
    // A full queue still accepts when the same cycle frees the head slot.
    assign space_s     = !full_s || pop_fire_s;
    assign cpu_push_s  = bus.cpu_out_valid && space_s;
    assign seed_push_s = bus.seed_valid && !bus.cpu_out_valid && space_s;
    assign push_s      = cpu_push_s || seed_push_s;

    // Select push source and compute next occupancy and high-watermark.
    always_comb begin
        push_data_s = {bus.seed_cc_id, bus.seed_pc};
        occ_next_s  = occ_r;
        max_next_s  = max_occ_r;
        if (cpu_push_s) begin
            push_data_s = {bus.cpu_out_cc_id, bus.cpu_out_pc};
        end else begin
            push_data_s = {bus.seed_cc_id, bus.seed_pc};
        end
        case ({push_s, pop_fire_s})
            2'b10:   occ_next_s = occ_r + OCC_ONE;
            2'b01:   occ_next_s = occ_r - OCC_ONE;
            default: occ_next_s = occ_r;
        endcase
        if (occ_next_s > max_occ_r) begin
            max_next_s = occ_next_s;
        end else begin
            max_next_s = max_occ_r;
        end
    end

    // Entry storage; stale contents are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wp_r] <= push_data_s;
        end
    end

    // Pointers, occupancy and high-watermark.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_r      <= PTR_ZERO;
            rp_r      <= PTR_ZERO;
            occ_r     <= OCC_ZERO;
            max_occ_r <= OCC_ZERO;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_fire_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            occ_r     <= occ_next_s;
            max_occ_r <= max_next_s;
        end
    end

    assign bus.seed_ready    = !bus.cpu_out_valid && space_s;
    assign bus.cpu_out_ready = space_s;
    assign bus.cpu_in_valid  = !empty_s;
    assign bus.cpu_in_pc     = mem_r[rp_r][PC_WIDTH-1:0];
    assign bus.cpu_in_cc_id  = mem_r[rp_r][ENTRY_W-1:PC_WIDTH];
    assign bus.occupancy     = occ_r;
    assign bus.max_occupancy = max_occ_r;
    assign bus.full          = full_s;
    assign bus.empty         = empty_s;
    assign bus.idle          = empty_s && !bus.cpu_running && !bus.cpu_out_valid;
endmodule

// File: doc/regex_pc_dispatcher.md
# regex_pc_dispatcher

Circular PC work queue closing the loop around `regex_cpu_pipelined`: consumes the CPU's output PC stream (`output_pc*`, `output_cc_id`), accepts initial seed PCs from the string front-end, and re-issues queued (cc_id, pc) entries to the CPU's input PC port (`input_pc*`, `input_cc_id`). It also reports occupancy, a high-watermark and a global idle flag, which the top level uses to decide that a string has been fully explored.

## Interface
- `PC_WIDTH`, 9, PC bits per entry.
- `CC_ID_BITS`, 2, character-context id bits per entry.
- `FIFO_DEPTH_LOG2`, 3, queue depth = 2**FIFO_DEPTH_LOG2 entries (≥ 2).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_valid`  in  1  external seed entry offered.
- `seed_pc`  in  PC_WIDTH  seed PC.
- `seed_cc_id`  in  CC_ID_BITS  seed context id.
- `seed_ready`  out  1  seed accepted this cycle when high with `seed_valid`.
- `cpu_out_valid`  in  1  from CPU `output_pc_valid`.
- `cpu_out_pc`  in  PC_WIDTH  from CPU `output_pc`.
- `cpu_out_cc_id`  in  CC_ID_BITS  from CPU `output_cc_id`.
- `cpu_out_ready`  out  1  to CPU `output_pc_ready`.
- `cpu_in_valid`  out  1  to CPU `input_pc_valid`.
- `cpu_in_pc`  out  PC_WIDTH  to CPU `input_pc`.
- `cpu_in_cc_id`  out  CC_ID_BITS  to CPU `input_cc_id`.
- `cpu_in_ready`  in  1  from CPU `input_pc_ready`.
- `cpu_running`  in  1  from CPU `running`.
- `occupancy`  out  FIFO_DEPTH_LOG2+1  registered entry count.
- `max_occupancy`  out  FIFO_DEPTH_LOG2+1  registered high-watermark since reset.
- `full`, `empty`  out  1  combinational from `occupancy`.
- `idle`  out  1  queue empty, CPU not running, no CPU output pending.

## Operation
- Storage: 2**FIFO_DEPTH_LOG2 entries of {cc_id, pc}; write pointer `wp`, read pointer `rp`, each FIFO_DEPTH_LOG2 bits, wrap modulo depth naturally; count held separately in `occupancy`.
- Push sources, at most one push per cycle:
  - CPU push fires when `cpu_out_valid && cpu_out_ready`; `cpu_out_ready = !full || pop_fire`.
  - Seed push fires when `seed_valid && seed_ready`; `seed_ready = !cpu_out_valid && (!full || pop_fire)`. CPU output always has priority; seed stalls while CPU output is offered.
- Pop: `cpu_in_valid = !empty`; `cpu_in_pc/cc_id` = entry at `rp` (combinational read, stable while `cpu_in_valid && !cpu_in_ready`). Pop fires on `cpu_in_valid && cpu_in_ready`.
- Counter: push only → +1; pop only → −1; push and pop same cycle → unchanged, both pointers advance. Push when full allowed only with simultaneous pop (pass-through slot reuse, no bypass: pushed entry is written at `wp`, popped entry read at `rp`).
- Entries are passed unmodified; cc_id is never rewritten (CPU already advances it).
- `max_occupancy` ← max(`max_occupancy`, next occupancy) each cycle.
- `idle = empty && !cpu_running && !cpu_out_valid`.

## Timing
- Reset (synchronous, `rst` high at an edge): `wp=rp=0`, `occupancy=0`, `max_occupancy=0`; thus `empty=1`, `full=0`, `cpu_in_valid=0`, `cpu_out_ready=1`, `seed_ready=!cpu_out_valid`. Reset mid-operation discards all entries; pending handshakes in that cycle are ignored.
- Push → pop latency: entry pushed at edge N is presented with `cpu_in_valid=1` in the cycle after edge N (1 cycle). No same-cycle bypass when empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- Order: strict FIFO across both sources, by acceptance cycle.
- `occupancy` never exceeds 2**FIFO_DEPTH_LOG2 and never underflows; a full queue with no pop holds both readies low.
- Wrap-around: after 2**FIFO_DEPTH_LOG2 pushes `wp` returns to 0; contents preserved.

## Test plan
- Reset: assert `rst` one cycle mid-stream with 3 entries queued → next cycle `occupancy=0`, `max_occupancy=0`, `empty=1`, `cpu_in_valid=0`, `idle=1` (with `cpu_running=0`).
- Seed then issue: seed (pc=0x0AA, cc=1) with `cpu_in_ready=0` → next cycle `cpu_in_valid=1`, pc=0x0AA, cc=1, held 5 cycles; raise ready → popped, `empty=1` next cycle.
- Priority: `seed_valid` and `cpu_out_valid` (pc=0x0AB, cc=2) same cycle → `seed_ready=0`, CPU entry accepted; seed accepted next cycle; issue order 0x0AB then seed.
- Full: 8 pushes (pc 0x100..0x107), no pops → `full=1`, `cpu_out_ready=0`, `max_occupancy=8`; then pop+push same cycle with pc=0x108 → occupancy stays 8; drain yields 0x101..0x108 in order.
- Wrap: 20 interleaved push/pop pairs with random pc/cc → output sequence equals input sequence, `max_occupancy ≤ 2`.
- Idle: empty queue, `cpu_running=1` → `idle=0`; `cpu_running=0`, `cpu_out_valid=1` → `idle=0`; both low → `idle=1`.
